gshare_predictor: RTL and testbench
===================================

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 SHALL have parameter HIST_BITS, default 10: global history length; the BHT holds 2^HIST_BITS entries.
REQ-002 SHALL have parameter BTB_IDX_BITS, default 5: the BTB holds 2^BTB_IDX_BITS direct-mapped entries.
REQ-003 SHALL have parameter CNT_INIT, default 2'b01: counter reset value (weakly not-taken).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 fetch_en  input  1  fetch advancing this cycle (0 during stall).
REQ-007 fetch_pc  input  32  PC being fetched.
REQ-008 pred_taken  output  1  predict redirect: counter[1] & btb_hit.
REQ-009 pred_target  output  32  BTB target; 0 when btb_hit=0.
REQ-010 pred_idx  output  HIST_BITS  BHT index used; carried down the pipe.
REQ-011 pred_ghr  output  HIST_BITS  GHR before this lookup's speculative shift; carried down the pipe.
REQ-012 upd_en  input  1  resolved control-flow instruction in EX.
REQ-013 upd_is_jump  input  1  resolved instruction is JAL/JALR (always taken).
REQ-014 upd_pc  input  32  PC of the resolved instruction.
REQ-015 upd_idx  input  HIST_BITS  pred_idx carried with it.
REQ-016 upd_ghr  input  HIST_BITS  pred_ghr carried with it.
REQ-017 upd_taken  input  1  actual outcome.
REQ-018 upd_target  input  32  actual target (ALU output).
REQ-019 upd_mispredict  input  1  direction or target mispredicted; pipeline flushes.
REQ-020 stat_branches, stat_mispredicts  output  32  each upd_en / upd_en&upd_mispredict event.

Function
REQ-021 Lookup SHALL be combinational, zero latency: idx = fetch_pc[HIST_BITS+1:2] XOR ghr.
REQ-022 BTB index SHALL be fetch_pc[BTB_IDX_BITS+1:2], tag fetch_pc[31:BTB_IDX_BITS+2]; btb_hit = valid & tag match.
REQ-023 On fetch_en & ~upd_mispredict, GHR SHALL shift left one bit, inserting pred_taken at bit 0.
REQ-024 On upd_en & upd_mispredict, GHR SHALL become {upd_ghr[HIST_BITS-2:0], upd_taken}; this overrides REQ-023 in the same cycle.
REQ-025 On upd_en & ~upd_is_jump, BHT[upd_idx] SHALL saturate-increment if upd_taken else saturate-decrement (3 stays 3, 0 stays 0).
REQ-026 On upd_en & upd_is_jump, BHT[upd_idx] SHALL be set to 2'b11.
REQ-027 On upd_en & upd_taken, the BTB entry for upd_pc SHALL be written (valid=1, tag, upd_target); not-taken updates leave the BTB unchanged.
REQ-028 Same-cycle lookup and update of one entry SHALL return the pre-update value (read-old).
REQ-029 Statistics counters SHALL saturate at 32'hFFFF_FFFF.
REQ-030 fetch_en=0 SHALL freeze GHR; updates still proceed.
REQ-031 upd_en=0 SHALL leave BHT, BTB and statistics unchanged regardless of the other upd_* inputs.

Reset
REQ-032 rst_n=0 SHALL immediately, without a clock, set: GHR=0, all BHT counters=CNT_INIT, all BTB valid bits=0, statistics=0.
REQ-033 During and after reset the outputs SHALL be pred_taken=0, pred_target=0, pred_ghr=0, pred_idx=fetch_pc[HIST_BITS+1:2].
REQ-034 Reset asserted mid-update SHALL discard that update.

Structure
REQ-035 The shared rv32i_types package SHALL hold typedef bht_cnt_t (2-bit) and constants CNT_STRONG_T=2'b11 and CNT_WEAK_NT=2'b01.
REQ-036 The BTB SHALL be a sub-module named pred_btb with a parameterised index width, one read port and one write port.

Verification
REQ-037 Reset, then fetch_pc=0x100 -> pred_taken=0, pred_target=0, pred_idx=0x040, pred_ghr=0.
REQ-038 Three updates: upd_pc=0x100, upd_idx=0x040, taken, target 0x200, ghr 0; then lookup with GHR forced to 0 -> pred_taken=1, pred_target=0x200, counter=3.
REQ-039 Fetch six cycles with pred_taken=1 -> GHR=0x03F; then mispredict update with upd_ghr=0x005, taken=0 -> GHR=0x00A on the next cycle, with no speculative shift in that cycle.
REQ-040 Same cycle: update idx 0x040 to counter 2 and lookup the same idx -> old value observed; new value visible next cycle.
REQ-041 HIST_BITS=4, BTB_IDX_BITS=2: aliasing PCs 0x10 and 0x20 -> BTB tag mismatch gives pred_taken=0; GHR wraps correctly within 4 bits.
REQ-042 Assert rst_n mid-run with 5 mispredicts recorded -> statistics=0 and pred_taken=0 with no clock edge.

Source files
------------

// File: rtl/rv32i_types.sv
// rv32i_types: shared predictor types, counter constants and the 2-bit counter update rule
package rv32i_types;
  typedef logic [1:0] bht_cnt_t;
  localparam bht_cnt_t CNT_STRONG_T = 2'b11;
  localparam bht_cnt_t CNT_WEAK_NT  = 2'b01;
  function automatic bht_cnt_t cnt_next(bht_cnt_t c, logic taken, logic jump);
    return jump ? CNT_STRONG_T : taken ? ((c == 2'b11) ? c : c + 2'b01) : ((c == 2'b00) ? c : c - 2'b01);
  endfunction
endpackage

// File: rtl/gshare_predictor_if.sv
// gshare_predictor_if: fetch lookup, EX resolution update and statistics bundle
interface gshare_predictor_if #(parameter int HIST_BITS = 10);
  logic                 fetch_en;
  logic [31:0]          fetch_pc;
  logic                 pred_taken;
  logic [31:0]          pred_target;
  logic [HIST_BITS-1:0] pred_idx;
  logic [HIST_BITS-1:0] pred_ghr;
  logic                 upd_en;
  logic                 upd_is_jump;
  logic [31:0]          upd_pc;
  logic [HIST_BITS-1:0] upd_idx;
  logic [HIST_BITS-1:0] upd_ghr;
  logic                 upd_taken;
  logic [31:0]          upd_target;
  logic                 upd_mispredict;
  logic [31:0]          stat_branches;
  logic [31:0]          stat_mispredicts;
  modport master (
    output fetch_en, fetch_pc, upd_en, upd_is_jump, upd_pc, upd_idx, upd_ghr, upd_taken, upd_target, upd_mispredict,
    input  pred_taken, pred_target, pred_idx, pred_ghr, stat_branches, stat_mispredicts
  );
  modport slave (
    input  fetch_en, fetch_pc, upd_en, upd_is_jump, upd_pc, upd_idx, upd_ghr, upd_taken, upd_target, upd_mispredict,
    output pred_taken, pred_target, pred_idx, pred_ghr, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/pred_btb.sv
// pred_btb: direct-mapped branch target buffer, one combinational read port and one write port
module pred_btb #(
  parameter int IDX_BITS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:2] rd_pc,
  output logic        rd_hit,
  output logic [31:0] rd_target,
  input  logic        wr_en,
  input  logic [31:2] wr_pc,
  input  logic [31:0] wr_target
);
  localparam int TAG_BITS = 30 - IDX_BITS;
  localparam int ENTRIES = 1 << IDX_BITS;
  logic [ENTRIES-1:0]  valid;
  logic [TAG_BITS-1:0] tag [ENTRIES];
  logic [31:0]         target [ENTRIES];
  logic [IDX_BITS-1:0] rd_i, wr_i;
  assign rd_i = rd_pc[IDX_BITS+1:2];
  assign wr_i = wr_pc[IDX_BITS+1:2];
  assign rd_hit = valid[rd_i] && (tag[rd_i] == rd_pc[31:IDX_BITS+2]);
  assign rd_target = rd_hit ? target[rd_i] : '0;
  // valid bits clear asynchronously; a write marks its entry live
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid <= '0;
    else if (wr_en) valid[wr_i] <= 1'b1;
  end
  // tag and target storage needs no reset, it is guarded by valid
  always_ff @(posedge clk) begin
    if (wr_en && rst_n) begin
      tag[wr_i] <= wr_pc[31:IDX_BITS+2];
      target[wr_i] <= wr_target;
    end
  end
endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: global-history XOR PC indexed 2-bit counters plus BTB, zero-latency lookup
module gshare_predictor
  import rv32i_types::*;
#(
  parameter int       HIST_BITS    = 10,
  parameter int       BTB_IDX_BITS = 5,
  parameter bht_cnt_t CNT_INIT     = CNT_WEAK_NT
) (
  input logic                   clk,
  input logic                   rst_n,
  gshare_predictor_if.slave     bp
);
  localparam int ENTRIES = 1 << HIST_BITS;
  bht_cnt_t             bht [ENTRIES];
  logic [HIST_BITS-1:0] ghr, idx;
  logic                 btb_hit;
  logic [31:0]          btb_target, stat_br, stat_mis;
  logic                 unused_bits;
  assign unused_bits = ^{bp.fetch_pc[1:0], bp.upd_pc[1:0], bp.upd_ghr[HIST_BITS-1]};
  assign idx = bp.fetch_pc[HIST_BITS+1:2] ^ ghr;
  pred_btb #(.IDX_BITS(BTB_IDX_BITS)) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_pc     (bp.fetch_pc[31:2]),
    .rd_hit    (btb_hit),
    .rd_target (btb_target),
    .wr_en     (bp.upd_en & bp.upd_taken),
    .wr_pc     (bp.upd_pc[31:2]),
    .wr_target (bp.upd_target)
  );
  assign bp.pred_taken = bht[idx][1] & btb_hit;
  assign bp.pred_target = btb_target;
  assign bp.pred_idx = idx;
  assign bp.pred_ghr = ghr;
  assign bp.stat_branches = stat_br;
  assign bp.stat_mispredicts = stat_mis;
  // history: mispredict recovery wins over the speculative shift; a stall freezes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ghr <= '0;
    else if (bp.upd_en && bp.upd_mispredict) ghr <= {bp.upd_ghr[HIST_BITS-2:0], bp.upd_taken};
    else if (bp.fetch_en && !bp.upd_mispredict) ghr <= {ghr[HIST_BITS-2:0], bp.pred_taken};
  end
  // counter table trained by resolved branches; jumps force strongly taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < ENTRIES; i++) bht[i] <= CNT_INIT;
    else if (bp.upd_en) bht[bp.upd_idx] <= cnt_next(bht[bp.upd_idx], bp.upd_taken, bp.upd_is_jump);
  end
  // saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br <= '0;
      stat_mis <= '0;
    end else if (bp.upd_en) begin
      stat_br <= stat_br + {31'b0, ~&stat_br};
      stat_mis <= stat_mis + {31'b0, bp.upd_mispredict & ~&stat_mis};
    end
  end
endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: directed stimulus with queued expectations drained by a monitor
module tb_gshare_predictor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  gshare_predictor_if #(.HIST_BITS(10)) bif();
  gshare_predictor_if #(.HIST_BITS(4))  sif();
  gshare_predictor dut (.clk(clk), .rst_n(rst_n), .bp(bif.slave));
  gshare_predictor #(.HIST_BITS(4), .BTB_IDX_BITS(2)) dut_s (.clk(clk), .rst_n(rst_n), .bp(sif.slave));

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  event chk_ev;

  function automatic logic [31:0] probe(int k);
    case (k)
      0: return {31'b0, bif.pred_taken};
      1: return bif.pred_target;
      2: return {22'b0, bif.pred_idx};
      3: return {22'b0, bif.pred_ghr};
      4: return bif.stat_branches;
      5: return bif.stat_mispredicts;
      6: return {31'b0, sif.pred_taken};
      7: return sif.pred_target;
      8: return {28'b0, sif.pred_ghr};
      default: return {28'b0, sif.pred_idx};
    endcase
  endfunction

  task automatic expect_val(string n, int k, logic [31:0] e);
    q.push_back('{n, k, e});
  endtask

  task automatic expect_big(string n, logic t, logic [31:0] tgt, logic [9:0] ix, logic [9:0] g);
    expect_val({n, "_taken"}, 0, {31'b0, t});
    expect_val({n, "_target"}, 1, tgt);
    expect_val({n, "_idx"}, 2, {22'b0, ix});
    expect_val({n, "_ghr"}, 3, {22'b0, g});
  endtask

  task automatic expect_stats(string n, logic [31:0] br, logic [31:0] mis);
    expect_val({n, "_branches"}, 4, br);
    expect_val({n, "_mispredicts"}, 5, mis);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bupd(logic [31:0] pc, logic [9:0] ix, logic [9:0] g, logic t, logic j, logic m, logic [31:0] tgt);
    bif.upd_en = 1'b1;
    bif.upd_pc = pc;
    bif.upd_idx = ix;
    bif.upd_ghr = g;
    bif.upd_taken = t;
    bif.upd_is_jump = j;
    bif.upd_mispredict = m;
    bif.upd_target = tgt;
  endtask

  task automatic supd(logic [31:0] pc, logic [3:0] ix, logic [3:0] g, logic t, logic j, logic m, logic [31:0] tgt);
    sif.upd_en = 1'b1;
    sif.upd_pc = pc;
    sif.upd_idx = ix;
    sif.upd_ghr = g;
    sif.upd_taken = t;
    sif.upd_is_jump = j;
    sif.upd_mispredict = m;
    sif.upd_target = tgt;
  endtask

  // monitor: compare every queued expectation at the falling edge or on an explicit strobe
  initial begin
    exp_t x;
    logic [31:0] got;
    forever begin
      @(negedge clk or chk_ev);
      while (q.size() > 0) begin
        x = q.pop_front();
        got = probe(x.kind);
        checks++;
        if (got !== x.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", x.name, got, x.exp);
        end
      end
    end
  end

  initial begin
    logic [9:0] train [5];
    train = '{10'h041, 10'h043, 10'h047, 10'h04F, 10'h05F};
    bif.fetch_en = 1'b0;
    bif.fetch_pc = 32'h100;
    bupd(32'h0, 10'h0, 10'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    bif.upd_en = 1'b0;
    sif.fetch_en = 1'b0;
    sif.fetch_pc = 32'h0;
    supd(32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    sif.upd_en = 1'b0;
    #2;
    expect_big("in_reset", 1'b0, 32'h0, 10'h040, 10'h000);
    expect_stats("in_reset", 32'd0, 32'd0);
    -> chk_ev;
    tick;
    rst_n = 1'b1;
    expect_big("post_reset", 1'b0, 32'h0, 10'h040, 10'h000);
    tick;
    bupd(32'h100, 10'h040, 10'h000, 1'b1, 1'b0, 1'b0, 32'h200);
    expect_val("upd1_read_old", 0, 32'd0);
    tick;
    expect_val("upd2_read_old", 0, 32'd1);
    expect_val("upd2_target", 1, 32'h200);
    tick;
    tick;
    bif.upd_en = 1'b0;
    expect_big("trained", 1'b1, 32'h200, 10'h040, 10'h000);
    expect_stats("trained", 32'd3, 32'd0);
    foreach (train[i]) begin
      tick;
      bupd(32'h100, train[i], 10'h000, 1'b1, 1'b1, 1'b0, 32'h200);
    end
    tick;
    bif.upd_en = 1'b0;
    bif.fetch_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick;
      expect_val($sformatf("spec_ghr%0d", i), 3, (32'd1 << i) - 32'd1);
      expect_val($sformatf("spec_taken%0d", i), 0, 32'd1);
    end
    tick;
    bif.fetch_en = 1'b0;
    expect_val("ghr_after6", 3, 32'h03F);
    expect_stats("after_jumps", 32'd8, 32'd0);
    tick;
    expect_val("ghr_frozen", 3, 32'h03F);
    tick;
    bif.fetch_en = 1'b1;
    bupd(32'h300, 10'h3FF, 10'h005, 1'b0, 1'b0, 1'b1, 32'h304);
    tick;
    bif.fetch_en = 1'b0;
    bif.upd_en = 1'b0;
    bif.upd_mispredict = 1'b0;
    bif.fetch_pc = 32'h300;
    expect_val("ghr_recovered", 3, 32'h00A);
    expect_val("nt_no_btb_write", 1, 32'h0);
    expect_stats("after_mispredict", 32'd9, 32'd1);
    tick;
    bif.fetch_pc = 32'h100;
    bupd(32'h300, 10'h3FF, 10'h000, 1'b0, 1'b0, 1'b1, 32'h0);
    tick;
    bupd(32'h100, 10'h040, 10'h000, 1'b0, 1'b0, 1'b0, 32'h200);
    expect_val("ghr_zeroed", 3, 32'h0);
    expect_val("dec3_read_old", 0, 32'd1);
    tick;
    expect_val("dec2_read_old", 0, 32'd1);
    tick;
    bif.upd_en = 1'b0;
    bif.upd_taken = 1'b1;
    bif.upd_is_jump = 1'b1;
    bif.upd_mispredict = 1'b1;
    expect_val("dec_visible", 0, 32'd0);
    tick;
    expect_val("upd_en0_taken", 0, 32'd0);
    expect_val("upd_en0_ghr", 3, 32'h0);
    expect_stats("upd_en0", 32'd12, 32'd2);
    tick;
    bupd(32'h100, 10'h040, 10'h000, 1'b0, 1'b0, 1'b0, 32'h200);
    tick;
    tick;
    bif.upd_taken = 1'b1;
    tick;
    bif.upd_en = 1'b0;
    expect_val("sat_low", 0, 32'd0);
    tick;
    bif.upd_en = 1'b1;
    tick;
    bif.upd_en = 1'b0;
    expect_val("sat_low_recover", 0, 32'd1);
    expect_val("sat_low_branches", 4, 32'd16);
    repeat (3) begin
      tick;
      bupd(32'h300, 10'h3FF, 10'h000, 1'b0, 1'b0, 1'b1, 32'h0);
    end
    tick;
    bif.upd_en = 1'b0;
    bif.upd_mispredict = 1'b0;
    expect_stats("five_mis", 32'd19, 32'd5);
    expect_val("pre_reset_taken", 0, 32'd1);
    tick;
    bupd(32'h100, 10'h040, 10'h000, 1'b1, 1'b1, 1'b1, 32'h999);
    #2;
    rst_n = 1'b0;
    #1;
    expect_big("async_reset", 1'b0, 32'h0, 10'h040, 10'h000);
    expect_stats("async_reset", 32'd0, 32'd0);
    -> chk_ev;
    tick;
    bif.upd_en = 1'b0;
    bif.upd_mispredict = 1'b0;
    rst_n = 1'b1;
    expect_big("update_discarded", 1'b0, 32'h0, 10'h040, 10'h000);
    expect_stats("update_discarded", 32'd0, 32'd0);
    tick;
    supd(32'h10, 4'h4, 4'h0, 1'b1, 1'b1, 1'b0, 32'h80);
    tick;
    supd(32'h10, 4'h8, 4'h0, 1'b1, 1'b1, 1'b0, 32'h80);
    tick;
    sif.upd_en = 1'b0;
    sif.fetch_pc = 32'h10;
    expect_val("s_hit_taken", 6, 32'd1);
    expect_val("s_hit_target", 7, 32'h80);
    expect_val("s_hit_idx", 9, 32'h4);
    tick;
    sif.fetch_pc = 32'h20;
    expect_val("s_alias_taken", 6, 32'd0);
    expect_val("s_alias_target", 7, 32'h0);
    expect_val("s_alias_idx", 9, 32'h8);
    tick;
    supd(32'h30, 4'h0, 4'hF, 1'b1, 1'b0, 1'b1, 32'h40);
    tick;
    sif.upd_en = 1'b0;
    sif.upd_mispredict = 1'b0;
    sif.fetch_en = 1'b1;
    expect_val("s_ghr_restore", 8, 32'hF);
    expect_val("s_idx_xor", 9, 32'h7);
    expect_val("s_tag_evicted", 6, 32'd0);
    tick;
    sif.fetch_en = 1'b0;
    expect_val("s_ghr_wrap", 8, 32'hE);
    expect_val("s_idx_wrap", 9, 32'h6);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
